// File: rtl/multicycle_control.sv
// multicycle_control: multicycle RV32 subset control FSM with memory handshake and trap handling
module multicycle_control #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int TRAP_EN       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  input  logic       Lt,
  input  logic       Ltu,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       AddrMode,
  output logic       illegal,
  output logic       instr_done
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JALR     = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_LUI      = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [3:0] w_dec_next;
  logic [3:0] w_alu_fn;
  logic       r_illegal;
  logic       w_ready;
  logic       w_bad;
  logic       w_take;
  logic       w_trap_en;
  logic       w_pcw, w_irw, w_rw, w_mw, w_mr, w_done;

  assign w_ready   = (MEM_HANDSHAKE == 0) || mem_ready;
  assign w_trap_en = (TRAP_EN != 0);
  assign w_take    = (funct3[2] ? (funct3[1] ? Ltu : Lt) : Zero) ^ funct3[0];

  // Opcode dispatch out of DECODE; unknown opcodes and unsupported widths/conditions are flagged bad
  always_comb begin
    w_dec_next = S_FETCH;
    w_bad      = 1'b0;
    case (op)
      OP_LOAD:   begin w_dec_next = S_MEMADR; w_bad = !(funct3 == 3'b010 || funct3 == 3'b100); end
      OP_STORE:  begin w_dec_next = S_MEMADR; w_bad = !(funct3 == 3'b010 || funct3 == 3'b000); end
      OP_R:      w_dec_next = S_EXECR;
      OP_I:      w_dec_next = S_EXECI;
      OP_BRANCH: begin w_dec_next = S_BRANCH; w_bad = (funct3[2:1] == 2'b01); end
      OP_JAL:    w_dec_next = S_JUMP;
      OP_JALR:   w_dec_next = S_JALR;
      OP_LUI:    w_dec_next = S_LUI;
      default:   w_bad = 1'b1;
    endcase
  end

  // ALU operation for register and immediate arithmetic; only R-type can request subtract
  always_comb begin
    w_alu_fn = 4'b0000;
    case (funct3)
      3'b000:  w_alu_fn = (op == OP_R && funct7) ? 4'b0001 : 4'b0000;
      3'b001:  w_alu_fn = 4'b0101;
      3'b010:  w_alu_fn = 4'b1000;
      3'b011:  w_alu_fn = 4'b1001;
      3'b100:  w_alu_fn = 4'b0100;
      3'b101:  w_alu_fn = funct7 ? 4'b0110 : 4'b0111;
      3'b110:  w_alu_fn = 4'b0011;
      default: w_alu_fn = 4'b0010;
    endcase
  end

  // Immediate format follows the opcode regardless of state
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_STORE:  ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_LUI:    ImmSrc = 3'b011;
      OP_JAL:    ImmSrc = 3'b100;
      default:   ImmSrc = 3'b000;
    endcase
  end

  // Next state and per-state datapath controls; enables are gated by reset afterwards
  always_comb begin
    w_next     = r_state;
    w_pcw      = 1'b0;
    w_irw      = 1'b0;
    w_rw       = 1'b0;
    w_mw       = 1'b0;
    w_mr       = 1'b0;
    w_done     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 4'b0000;
    AddrMode   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mr      = 1'b1;
        w_irw     = w_ready;
        w_pcw     = w_ready;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_next    = w_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        w_done  = w_bad && !w_trap_en;
        w_next  = !w_bad ? w_dec_next : (w_trap_en ? S_TRAP : S_FETCH);
      end
      S_MEMADR: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        AddrMode = (funct3 != 3'b010);
        w_next   = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc   = 1'b1;
        w_mr     = 1'b1;
        AddrMode = (funct3 != 3'b010);
        w_next   = w_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_rw      = 1'b1;
        w_done    = 1'b1;
        AddrMode  = (funct3 != 3'b010);
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        w_mw     = 1'b1;
        w_done   = w_ready;
        AddrMode = (funct3 != 3'b010);
        w_next   = w_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = w_alu_fn;
        w_next     = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = w_alu_fn;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        w_rw   = 1'b1;
        w_done = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 4'b0001;
        w_pcw      = w_take;
        w_done     = 1'b1;
        w_next     = S_FETCH;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = S_JUMP;
      end
      S_JUMP: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        w_pcw   = 1'b1;
        w_next  = S_ALUWB;
      end
      S_LUI: begin
        ResultSrc = 2'b11;
        w_rw      = 1'b1;
        w_done    = 1'b1;
        w_next    = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  assign PCWrite    = w_pcw  && !rst;
  assign IRWrite    = w_irw  && !rst;
  assign RegWrite   = w_rw   && !rst;
  assign MemWrite   = w_mw   && !rst;
  assign MemRead    = w_mr   && !rst;
  assign instr_done = w_done && !rst;
  assign illegal    = r_illegal;

  // State register; the illegal flag latches on entry to TRAP and only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal || (r_state == S_DECODE && w_bad && w_trap_en);
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed cycle-by-cycle check of the multicycle control FSM
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst1 = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7 = 1'b0;
  logic       Zero = 1'b0, Lt = 1'b0, Ltu = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc, AddrMode, illegal, instr_done;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       PCWrite1, IRWrite1, RegWrite1, MemWrite1, MemRead1, AdrSrc1, AddrMode1, illegal1, instr_done1;
  logic [1:0] ALUSrcA1, ALUSrcB1, ResultSrc1;
  logic [2:0] ImmSrc1;
  logic [3:0] ALUControl1;
  logic [18:0] w_obs, w_obs1;
  int checks = 0;
  int errors = 0;

  localparam logic [18:0] EN_MASK = 19'h7C003;

  multicycle_control dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemRead(MemRead), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .AddrMode(AddrMode),
    .illegal(illegal), .instr_done(instr_done)
  );

  multicycle_control #(.MEM_HANDSHAKE(0), .TRAP_EN(0)) dut1 (
    .clk(clk), .rst(rst1), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
    .PCWrite(PCWrite1), .IRWrite(IRWrite1), .RegWrite(RegWrite1), .MemWrite(MemWrite1),
    .MemRead(MemRead1), .AdrSrc(AdrSrc1), .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1),
    .ResultSrc(ResultSrc1), .ImmSrc(ImmSrc1), .ALUControl(ALUControl1), .AddrMode(AddrMode1),
    .illegal(illegal1), .instr_done(instr_done1)
  );

  assign w_obs  = {PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc, ALUSrcA, ALUSrcB,
                   ResultSrc, ALUControl, AddrMode, illegal, instr_done};
  assign w_obs1 = {PCWrite1, IRWrite1, RegWrite1, MemWrite1, MemRead1, AdrSrc1, ALUSrcA1, ALUSrcB1,
                   ResultSrc1, ALUControl1, AddrMode1, illegal1, instr_done1};

  always #5 clk = ~clk;

  function automatic logic [18:0] cw(input logic pw, ir, rw, mw, mr, as, input logic [1:0] sa, sb, rs,
                                     input logic [3:0] alu, input logic am, il, dn);
    return {pw, ir, rw, mw, mr, as, sa, sb, rs, alu, am, il, dn};
  endfunction

  localparam logic [18:0] W_F    = {5'b11001, 1'b0, 2'b00, 2'b10, 2'b10, 4'b0000, 3'b000};
  localparam logic [18:0] W_D    = {5'b00000, 1'b0, 2'b01, 2'b01, 2'b00, 4'b0000, 3'b000};
  localparam logic [18:0] W_WB   = {5'b00100, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b001};

  task automatic chk(input string t, input logic [18:0] obs, input logic [18:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", t, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fd(input string t, input logic [2:0] imm);
    #1;
    chk({t, "_fetch"}, w_obs, W_F);
    tick();
    chk({t, "_decode"}, w_obs, W_D);
    chk({t, "_imm"}, {16'b0, ImmSrc}, {16'b0, imm});
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("reset_enables", w_obs & EN_MASK, 19'h0);
    rst = 1'b0;
    // add x3,x1,x2
    fd("add", 3'b000);
    chk("add_execr", w_obs, cw(0,0,0,0,0,0,2'b10,2'b00,2'b00,4'b0000,0,0,0));
    tick();
    chk("add_aluwb", w_obs, W_WB);
    tick();
    // sub
    funct7 = 1'b1;
    fd("sub", 3'b000);
    chk("sub_execr", w_obs, cw(0,0,0,0,0,0,2'b10,2'b00,2'b00,4'b0001,0,0,0));
    tick();
    chk("sub_aluwb", w_obs, W_WB);
    tick();
    // srai
    op = 7'b0010011; funct3 = 3'b101;
    fd("srai", 3'b000);
    chk("srai_execi", w_obs, cw(0,0,0,0,0,0,2'b10,2'b01,2'b00,4'b0110,0,0,0));
    tick();
    chk("srai_aluwb", w_obs, W_WB);
    tick();
    // addi with funct7 set is still add
    funct3 = 3'b000;
    fd("addi", 3'b000);
    chk("addi_execi", w_obs, cw(0,0,0,0,0,0,2'b10,2'b01,2'b00,4'b0000,0,0,0));
    tick();
    tick();
    // lbu with three stalled MEMREAD cycles
    op = 7'b0000011; funct3 = 3'b100; funct7 = 1'b0;
    fd("lbu", 3'b000);
    chk("lbu_memadr", w_obs, cw(0,0,0,0,0,0,2'b10,2'b01,2'b00,4'b0000,1,0,0));
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lbu_memread_stall", w_obs, cw(0,0,0,0,1,1,2'b00,2'b00,2'b00,4'b0000,1,0,0));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("lbu_memread_ready", w_obs, cw(0,0,0,0,1,1,2'b00,2'b00,2'b00,4'b0000,1,0,0));
    tick();
    chk("lbu_memwb", w_obs, cw(0,0,1,0,0,0,2'b00,2'b00,2'b01,4'b0000,1,0,1));
    tick();
    // sw, ready at once
    op = 7'b0100011; funct3 = 3'b010;
    fd("sw", 3'b001);
    chk("sw_memadr", w_obs, cw(0,0,0,0,0,0,2'b10,2'b01,2'b00,4'b0000,0,0,0));
    tick();
    chk("sw_memwrite", w_obs, cw(0,0,0,1,0,1,2'b00,2'b00,2'b00,4'b0000,0,0,1));
    tick();
    // sb stalled in MEMWRITE, then reset
    funct3 = 3'b000;
    fd("sb", 3'b001);
    mem_ready = 1'b0;
    tick();
    chk("sb_memwrite_wait", w_obs, cw(0,0,0,1,0,1,2'b00,2'b00,2'b00,4'b0000,1,0,0));
    rst = 1'b1;
    #1;
    chk("sb_rst_enables", w_obs & EN_MASK, 19'h0);
    tick();
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    chk("sb_rst_fetch", w_obs, W_F);
    // bne, both Zero values in the same BRANCH cycle
    op = 7'b1100011; funct3 = 3'b001; Zero = 1'b1;
    fd("bne", 3'b010);
    chk("bne_zero1", w_obs, cw(0,0,0,0,0,0,2'b10,2'b00,2'b00,4'b0001,0,0,1));
    Zero = 1'b0;
    #1;
    chk("bne_zero0", w_obs, cw(1,0,0,0,0,0,2'b10,2'b00,2'b00,4'b0001,0,0,1));
    tick();
    // bgeu with Ltu=1 not taken, Ltu=0 taken
    funct3 = 3'b111; Ltu = 1'b1;
    fd("bgeu", 3'b010);
    chk("bgeu_lt", w_obs, cw(0,0,0,0,0,0,2'b10,2'b00,2'b00,4'b0001,0,0,1));
    Ltu = 1'b0;
    #1;
    chk("bgeu_ge", w_obs, cw(1,0,0,0,0,0,2'b10,2'b00,2'b00,4'b0001,0,0,1));
    tick();
    // jalr
    op = 7'b1100111; funct3 = 3'b000;
    fd("jalr", 3'b000);
    chk("jalr_jalr", w_obs, cw(0,0,0,0,0,0,2'b10,2'b01,2'b00,4'b0000,0,0,0));
    tick();
    chk("jalr_jump", w_obs, cw(1,0,0,0,0,0,2'b01,2'b10,2'b00,4'b0000,0,0,0));
    tick();
    chk("jalr_aluwb", w_obs, W_WB);
    tick();
    // jal
    op = 7'b1101111;
    fd("jal", 3'b100);
    chk("jal_jump", w_obs, cw(1,0,0,0,0,0,2'b01,2'b10,2'b00,4'b0000,0,0,0));
    tick();
    chk("jal_aluwb", w_obs, W_WB);
    tick();
    // lui
    op = 7'b0110111;
    fd("lui", 3'b011);
    chk("lui_lui", w_obs, cw(0,0,1,0,0,0,2'b00,2'b00,2'b11,4'b0000,0,0,1));
    tick();
    // illegal opcode traps and holds
    op = 7'b1111111;
    fd("ill", 3'b000);
    op = 7'b0110011;
    for (int i = 0; i < 10; i++) begin
      chk("ill_trap_hold", w_obs, cw(0,0,0,0,0,0,2'b00,2'b00,2'b00,4'b0000,0,1,0));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("ill_rst_fetch", w_obs, W_F);
    // no-handshake, no-trap variant: illegal retires as NOP, fetch ignores mem_ready
    rst1 = 1'b0; op = 7'b1111111; mem_ready = 1'b0;
    #1;
    chk("nt_fetch", w_obs1, W_F);
    tick();
    chk("nt_decode_done", w_obs1, cw(0,0,0,0,0,0,2'b01,2'b01,2'b00,4'b0000,0,0,1));
    tick();
    chk("nt_refetch", w_obs1, W_F);
    op = 7'b0000011; funct3 = 3'b001;
    tick();
    chk("nt_badload_done", w_obs1, cw(0,0,0,0,0,0,2'b01,2'b01,2'b00,4'b0000,0,0,1));
    tick();
    chk("nt_badload_refetch", w_obs1, W_F);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
